secded_stream_dec: RTL and testbench

- Parametrised, pipelined extended-Hamming (SECDED) decoder. Successor to the fixed 11-data/16-code program-2 decode flow.
- Accepts one codeword per cycle on a valid/ready stream. Emits corrected data plus a 2-bit status matching the program-2 output convention: 00 = clean, 01 = single corrected, 1x = double/uncorrectable.
- Sits between the data-memory read path and the result write-back path of the top level.

---
 rtl/secded_pkg.sv | 73 +++++++
 rtl/secded_syndrome.sv | 21 ++
 rtl/secded_stream_dec.sv | 136 +++++++++++++
 tb/tb_secded_stream_dec.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared types, status codes and helper functions for the SECDED stream decoder.
// The optional error counters are enabled with the SECDED_ERR_CNT_EN macro.
package secded_pkg;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_SGL   = 2'b01;
    localparam logic [1:0] ST_DBL   = 2'b10;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int calc_p_w(input int data_w);
        int r;
        r = 0;
        for (int p = 31; p >= 1; p--) begin
            if ((longint'(1) << p) >= longint'(data_w + p + 1)) begin
                r = p;
            end
        end
        return r;
    endfunction

    // Codeword position of data bit k (non-power-of-two positions, LSB first).
    function automatic int data_pos(input int k);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int i = 3; i < 256; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) begin
                    r = i;
                end
                n++;
            end
        end
        return r;
    endfunction

    // Positions whose index has bit k set: the coverage set of parity 2^k.
    function automatic logic [63:0] cover_mask(input int k);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[6'(i)] = ((i >> k) & 1) != 0;
        end
        return m;
    endfunction

    function automatic logic [63:0] secded_encode(
        input logic [63:0] data,
        input int          data_w
    );
        logic [63:0] c;
        int          s;
        int          pw;
        c  = '0;
        s  = 0;
        pw = calc_p_w(data_w);
        for (int k = 0; k < data_w; k++) begin
            c[6'(data_pos(k))] = data[6'(k)];
        end
        for (int i = 1; i < 64; i++) begin
            if (c[6'(i)]) begin
                s = s ^ i;
            end
        end
        for (int k = 0; k < pw; k++) begin
            c[6'(1 << k)] = s[5'(k)];
        end
        c[0] = ^c;
        return c;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
// Used by the first pipeline stage of secded_stream_dec.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int CODE_W = 16,
    parameter int P_W    = 4
) (
    input  logic [CODE_W-1:0] code,
    output logic [P_W-1:0]    syn,
    output logic              par
);

    for (genvar k = 0; k < P_W; k++) begin : g_syn
        localparam logic [63:0] MASK = cover_mask(k);
        assign syn[k] = ^(code & MASK[CODE_W-1:0]);
    end

    assign par = ^code;

endmodule

// File: rtl/secded_stream_dec.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream.
// Define SECDED_ERR_CNT_EN to add saturating single/double error counters.
module secded_stream_dec
    import secded_pkg::*;
#(
    parameter  int DATA_W = 11,
    localparam int P_W    = calc_p_w(DATA_W),
    localparam int CODE_W = DATA_W + P_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status
`ifdef SECDED_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       sgl_cnt,
    output logic [15:0]       dbl_cnt
`endif
);

    logic              adv1;
    logic              adv2;
    logic [P_W-1:0]    syn_c;
    logic              par_c;
    logic [DATA_W-1:0] raw_c;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [P_W-1:0]    s1_syn;
    logic              s1_par;

    logic              syn_zero;
    logic              syn_in;
    logic              flip;
    logic [1:0]        status_c;
    logic [DATA_W-1:0] hit;
    logic [DATA_W-1:0] data_c;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    secded_syndrome #(
        .CODE_W (CODE_W),
        .P_W    (P_W)
    ) u_syn (
        .code (in_code),
        .syn  (syn_c),
        .par  (par_c)
    );

    // Only the data field of the codeword travels on; parity positions
    // never reach the output, so a parity-bit flip needs no correction.
    for (genvar k = 0; k < DATA_W; k++) begin : g_bit
        localparam int POS = data_pos(k);
        assign raw_c[k]  = in_code[POS];
        assign hit[k]    = (s1_syn == P_W'(POS));
        assign data_c[k] = s1_data[k] ^ (flip && hit[k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= raw_c;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
            end
        end
    end

    assign syn_zero = (s1_syn == '0);
    assign syn_in   = (32'(s1_syn) < 32'(CODE_W));

    always_comb begin
        status_c = ST_CLEAN;
        flip     = 1'b0;
        unique case (1'b1)
            (syn_zero && !s1_par): status_c = ST_CLEAN;
            (syn_zero && s1_par):  status_c = ST_SGL;
            (!syn_zero && s1_par && syn_in): begin
                status_c = ST_SGL;
                flip     = 1'b1;
            end
            default: status_c = ST_DBL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= ST_CLEAN;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= data_c;
                out_status <= status_c;
            end
        end
    end

`ifdef SECDED_ERR_CNT_EN
    logic fire;
    assign fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (cnt_clr) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (fire) begin
            if (out_status[0] && sgl_cnt != 16'hFFFF) begin
                sgl_cnt <= sgl_cnt + 16'd1;
            end
            if (out_status[1] && dbl_cnt != 16'hFFFF) begin
                dbl_cnt <= dbl_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_secded_stream_dec.sv
// Directed self-checking bench for secded_stream_dec at DATA_W 11, 26 and 5.
// Counter checks are compiled in when SECDED_ERR_CNT_EN is defined.
module tb_secded_stream_dec;
    import secded_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_code;
    logic [10:0] a_out_data;
    logic [1:0]  a_out_status;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_code;
    logic [25:0] b_out_data;
    logic [1:0]  b_out_status;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [9:0]  c_in_code;
    logic [4:0]  c_out_data;
    logic [1:0]  c_out_status;

`ifdef SECDED_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] sgl_cnt, dbl_cnt;
    logic [15:0] b_sgl_cnt, b_dbl_cnt;
    logic [15:0] c_sgl_cnt, c_dbl_cnt;
    int          exp_sgl = 0;
    int          exp_dbl = 0;
`endif

    secded_stream_dec #(.DATA_W(11)) u_a (
        .clk (clk), .reset (reset),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_code (a_in_code),
        .out_valid (a_out_valid), .out_ready (a_out_ready),
        .out_data (a_out_data), .out_status (a_out_status)
`ifdef SECDED_ERR_CNT_EN
        , .cnt_clr (cnt_clr), .sgl_cnt (sgl_cnt), .dbl_cnt (dbl_cnt)
`endif
    );

    secded_stream_dec #(.DATA_W(26)) u_b (
        .clk (clk), .reset (reset),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_code (b_in_code),
        .out_valid (b_out_valid), .out_ready (b_out_ready),
        .out_data (b_out_data), .out_status (b_out_status)
`ifdef SECDED_ERR_CNT_EN
        , .cnt_clr (cnt_clr), .sgl_cnt (b_sgl_cnt), .dbl_cnt (b_dbl_cnt)
`endif
    );

    secded_stream_dec #(.DATA_W(5)) u_c (
        .clk (clk), .reset (reset),
        .in_valid (c_in_valid), .in_ready (c_in_ready), .in_code (c_in_code),
        .out_valid (c_out_valid), .out_ready (c_out_ready),
        .out_data (c_out_data), .out_status (c_out_status)
`ifdef SECDED_ERR_CNT_EN
        , .cnt_clr (cnt_clr), .sgl_cnt (c_sgl_cnt), .dbl_cnt (c_dbl_cnt)
`endif
    );

    typedef struct {
        logic [10:0] d;
        logic [1:0]  s;
        logic        cd;
    } exp_t;

    exp_t        q[$];
    logic        prev_stall = 1'b0;
    logic [10:0] held_d;
    logic [1:0]  held_s;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on DUT A: check any transferring result, then offer a word.
    task automatic cyc_a(input logic v, input logic [15:0] code,
                         input logic [10:0] ed, input logic [1:0] es,
                         input logic cd, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        a_out_ready = ordy;
        a_in_valid  = v;
        a_in_code   = code;
        #1;
        if (a_out_valid && ordy) begin
            chk("queue_has_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.cd) chk("a_data", 32'(a_out_data), 32'(e.d));
                chk("a_status", 32'(a_out_status), 32'(e.s));
`ifdef SECDED_ERR_CNT_EN
                if (e.s == ST_SGL) exp_sgl++;
                if (e.s == ST_DBL) exp_dbl++;
`endif
            end
        end
        if (a_out_valid && !ordy) begin
            if (prev_stall) begin
                chk("hold_data", 32'(a_out_data), 32'(held_d));
                chk("hold_status", 32'(a_out_status), 32'(held_s));
            end
            held_d     = a_out_data;
            held_s     = a_out_status;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
        acc = v && a_in_ready;
        if (acc) q.push_back('{ed, es, cd});
    endtask

    task automatic drain_a(input int max);
        logic acc;
        for (int i = 0; i < max && q.size() != 0; i++) begin
            cyc_a(1'b0, 16'h0, 11'h0, ST_CLEAN, 1'b0, 1'b1, acc);
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic xb(input logic [31:0] code, input logic [25:0] ed,
                      input logic [1:0] es);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_code  = code;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_valid", 32'(b_out_valid), 32'd1);
        chk("b_data", 32'(b_out_data), 32'(ed));
        chk("b_status", 32'(b_out_status), 32'(es));
    endtask

    task automatic xc(input logic [9:0] code, input logic [4:0] ed,
                      input logic [1:0] es);
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_code  = code;
        @(negedge clk);
        c_in_valid = 1'b0;
        @(negedge clk);
        chk("c_valid", 32'(c_out_valid), 32'd1);
        chk("c_data", 32'(c_out_data), 32'(ed));
        chk("c_status", 32'(c_out_status), 32'(es));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        blocked;
        int          idx;
        logic [10:0] d11;
        logic [15:0] c16;
        logic [25:0] d26;
        logic [31:0] c32;
        logic [4:0]  d5;
        logic [9:0]  c10;
        logic [10:0] bd[8];
        logic [15:0] bc[8];

        reset = 1'b0;
        a_in_valid = 0; a_in_code = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_code = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_code = '0; c_out_ready = 1;
`ifdef SECDED_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid_rel", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_out_status", 32'(a_out_status), 32'd0);

        chk("enc_ref", 32'(secded_encode(64'h1, 11)), 32'h000F);

        // Latency: accept at one edge, out_valid two edges later.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_code  = 16'h000F;
        #1;
        chk("lat_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("lat_not_yet", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(a_out_valid), 32'd1);
        chk("lat_data", 32'(a_out_data), 32'h001);
        chk("lat_status", 32'(a_out_status), 32'(ST_CLEAN));
        @(negedge clk);
        chk("lat_single_pulse", 32'(a_out_valid), 32'd0);

        cyc_a(1, 16'h0007, 11'h001, ST_SGL, 1, 1, acc);
        cyc_a(1, 16'h000E, 11'h001, ST_SGL, 1, 1, acc);
        cyc_a(1, 16'h0017, 11'h000, ST_DBL, 1, 1, acc);
        drain_a(10);

        for (int w = 0; w < 15; w++) begin
            d11 = 11'($urandom_range(0, 2047));
            c16 = 16'(secded_encode(64'(d11), 11));
            for (int p = 0; p < 16; p++) begin
                cyc_a(1, c16 ^ (16'd1 << p), d11, ST_SGL, 1, 1, acc);
                chk("sweep_acc", 32'(acc), 32'd1);
            end
            for (int p = 0; p < 15; p++) begin
                cyc_a(1, c16 ^ (16'd3 << p), 11'h0, ST_DBL, 0, 1, acc);
            end
        end
        drain_a(10);
`ifdef SECDED_ERR_CNT_EN
        chk("sgl_cnt", 32'(sgl_cnt), 32'(exp_sgl));
        chk("dbl_cnt", 32'(dbl_cnt), 32'(exp_dbl));
`endif

        for (int k = 0; k < 8; k++) begin
            bd[k] = 11'(k * 151 + 3);
            bc[k] = 16'(secded_encode(64'(bd[k]), 11));
        end
        idx = 0;
        blocked = 1'b0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            cyc_a(1, bc[idx], bd[idx], ST_CLEAN, 1, !(c >= 3 && c < 6), acc);
            if (!a_in_ready) blocked = 1'b1;
            if (acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd8);
        chk("bp_in_ready_dropped", 32'(blocked), 32'd1);
        drain_a(10);

`ifdef SECDED_ERR_CNT_EN
        cyc_a(1, 16'h0007, 11'h001, ST_SGL, 1, 1, acc);
        cyc_a(0, 16'h0, 11'h0, ST_CLEAN, 0, 1, acc);
        cnt_clr = 1'b1;
        cyc_a(0, 16'h0, 11'h0, ST_CLEAN, 0, 1, acc);
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_sgl = 0;
        exp_dbl = 0;
        chk("clr_wins_sgl", 32'(sgl_cnt), 32'd0);
        chk("clr_wins_dbl", 32'(dbl_cnt), 32'd0);
        cyc_a(1, 16'h0007, 11'h001, ST_SGL, 1, 1, acc);
        drain_a(10);
        @(negedge clk);
        chk("cnt_after_clr", 32'(sgl_cnt), 32'(exp_sgl));
`endif

        d26 = 26'h2A5_F00D;
        c32 = 32'(secded_encode(64'(d26), 26));
        xb(c32, d26, ST_CLEAN);
        for (int p = 0; p < 32; p++) begin
            xb(c32 ^ (32'd1 << p), d26, ST_SGL);
        end
`ifdef SECDED_ERR_CNT_EN
        chk("b_sgl_cnt", 32'(b_sgl_cnt), 32'd32);
`endif

        d5  = 5'h15;
        c10 = 10'(secded_encode(64'(d5), 5));
        xc(c10, d5, ST_CLEAN);
        for (int p = 0; p < 10; p++) begin
            xc(c10 ^ (10'd1 << p), d5, ST_SGL);
        end
        xc(10'h111, 5'h00, ST_DBL);

        // Reset with both stages full drops everything in flight.
        cyc_a(1, 16'h000F, 11'h001, ST_CLEAN, 1, 0, acc);
        cyc_a(1, 16'h0007, 11'h001, ST_SGL, 1, 0, acc);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("full_out_valid", 32'(a_out_valid), 32'd1);
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_data", 32'(a_out_data), 32'd0);
        chk("mid_rst_status", 32'(a_out_status), 32'd0);
        q.delete();
        prev_stall = 1'b0;
`ifdef SECDED_ERR_CNT_EN
        exp_sgl = 0;
        exp_dbl = 0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale_out", 32'(a_out_valid), 32'd0);
        end
`ifdef SECDED_ERR_CNT_EN
        chk("cnt_rst", 32'(sgl_cnt), 32'd0);
`endif
        cyc_a(1, 16'h0017, 11'h000, ST_DBL, 1, 1, acc);
        drain_a(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
